// File: rtl/i2s_serializer.sv
// I2S master transmitter: divides clk into sclk and shifts 24-bit left/right
// sample pairs out MSB first, 48 sclk periods per frame.
module i2s_serializer #(
   parameter int SCLK_DIV = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic [23:0] lft_chnnl,
   input  logic [23:0] rght_chnnl,
   output logic        I2S_sclk,
   output logic        I2S_ws,
   output logic        I2S_data,
   output logic        smpl_req,
   output logic        busy
);

   localparam int DIV_W = (SCLK_DIV > 2) ? $clog2(SCLK_DIV) : 1;
   localparam logic IDLE = 1'b0;
   localparam logic RUN  = 1'b1;

   logic             state;
   logic [DIV_W-1:0] div_cnt;
   logic [5:0]       slot;
   logic [5:0]       next_slot;
   logic [47:0]      shft_reg;
   logic             div_wrap;
   logic             sclk_fall;
   logic             frame_end;

   assign div_wrap  = (div_cnt == DIV_W'(SCLK_DIV - 1));
   assign sclk_fall = div_wrap & I2S_sclk;
   assign frame_end = (slot == 6'd47);
   assign next_slot = frame_end ? 6'd0 : slot + 6'd1;

   // Control path and registered outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         div_cnt  <= '0;
         slot     <= 6'd0;
         I2S_sclk <= 1'b0;
         I2S_ws   <= 1'b1;
         I2S_data <= 1'b0;
         smpl_req <= 1'b0;
         busy     <= 1'b0;
      end else begin
         smpl_req <= 1'b0;
         case (state)
            IDLE: begin
               div_cnt  <= '0;
               I2S_sclk <= 1'b0;
               I2S_ws   <= 1'b1;
               I2S_data <= 1'b0;
               busy     <= 1'b0;
               if (en) begin
                  // Dummy R0 slot: gives the receiver a ws fall to lock onto
                  state  <= RUN;
                  slot   <= 6'd47;
                  I2S_ws <= 1'b0;
                  busy   <= 1'b1;
               end
            end
            RUN: begin
               div_cnt <= div_wrap ? '0 : div_cnt + DIV_W'(1);
               if (div_wrap)
                  I2S_sclk <= ~I2S_sclk;
               if (sclk_fall) begin
                  if (frame_end && !en) begin
                     state    <= IDLE;
                     div_cnt  <= '0;
                     I2S_sclk <= 1'b0;
                     I2S_ws   <= 1'b1;
                     I2S_data <= 1'b0;
                     busy     <= 1'b0;
                  end else if (frame_end) begin
                     slot     <= 6'd0;
                     smpl_req <= 1'b1;
                     I2S_data <= lft_chnnl[23];
                     I2S_ws   <= 1'b0;
                  end else begin
                     slot     <= next_slot;
                     I2S_data <= shft_reg[46];
                     I2S_ws   <= (next_slot >= 6'd23) && (next_slot <= 6'd46);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Sample shifter: data only, its contents are don't-care until the first load
   always_ff @(posedge clk) begin
      if (state == RUN && sclk_fall) begin
         if (frame_end && en)
            shft_reg <= {lft_chnnl, rght_chnnl};
         else if (!frame_end)
            shft_reg <= {shft_reg[46:0], 1'b0};
      end
   end

endmodule

// File: tb/tb_i2s_serializer.sv
// Bench for i2s_serializer: two instances (SCLK_DIV 8 and 4) checked each clk
// against an arithmetic frame model, plus table-driven serial decode.
module tb_i2s_serializer;

   logic        clk = 1'b0;
   logic        rst_n, en;
   logic [23:0] lft, rght;
   logic        sclk8, ws8, data8, smpl8, busy8;
   logic        sclk4, ws4, data4, smpl4, busy4;

   always #5 clk = ~clk;

   i2s_serializer #(.SCLK_DIV(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .en(en), .lft_chnnl(lft), .rght_chnnl(rght),
      .I2S_sclk(sclk8), .I2S_ws(ws8), .I2S_data(data8), .smpl_req(smpl8), .busy(busy8));

   i2s_serializer #(.SCLK_DIV(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .en(en), .lft_chnnl(lft), .rght_chnnl(rght),
      .I2S_sclk(sclk4), .I2S_ws(ws4), .I2S_data(data4), .smpl_req(smpl4), .busy(busy4));

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   int dv [2] = '{8, 4};

   // Model: run flag, clk count since entering RUN, latched pair
   bit          m_run [2];
   int          m_n   [2];
   logic [23:0] m_l   [2];
   logic [23:0] m_r   [2];

   logic [1:0] q8[$];
   logic [1:0] q4[$];
   always @(posedge sclk8) q8.push_back({ws8, data8});
   always @(posedge sclk4) q4.push_back({ws4, data4});

   typedef struct {
      logic [23:0] l;
      logic [23:0] r;
      logic [23:0] exp_l;
      logic [23:0] exp_r;
   } vec_t;
   vec_t vecs [4];

   task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [4:0] act_out(input int i);
      if (i == 0) return {sclk8, ws8, data8, smpl8, busy8};
      return {sclk4, ws4, data4, smpl4, busy4};
   endfunction

   // {sclk, ws, data, smpl_req, busy}
   function automatic logic [4:0] exp_out(input int i);
      int d, b, ph, s;
      logic dt;
      if (!m_run[i]) return 5'b01000;
      d  = dv[i];
      b  = m_n[i] / (2 * d);
      ph = m_n[i] % (2 * d);
      s  = (47 + b) % 48;
      if (b == 0)      dt = 1'b0;
      else if (s < 24) dt = m_l[i][23 - s];
      else             dt = m_r[i][47 - s];
      return {ph >= d, (s >= 23) && (s <= 46), dt, (ph == 0) && (s == 0), 1'b1};
   endfunction

   task automatic model_step(input int i);
      int d, nn;
      d = dv[i];
      if (!rst_n) m_run[i] = 1'b0;
      else if (!m_run[i]) begin
         if (en) begin m_run[i] = 1'b1; m_n[i] = 0; end
      end else begin
         nn = m_n[i] + 1;
         if ((nn % (2 * d) == 0) && ((nn / (2 * d)) % 48 == 1)) begin
            if (!en) m_run[i] = 1'b0;
            else begin m_l[i] = lft; m_r[i] = rght; m_n[i] = nn; end
         end else m_n[i] = nn;
      end
   endtask

   task automatic tick();
      model_step(0);
      model_step(1);
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < 2; i++)
         chk($sformatf("cyc%0d_div%0d", cyc, dv[i]), 48'(act_out(i)), 48'(exp_out(i)));
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      while ((busy8 || busy4) && k < 2000) begin tick(); k++; end
      chk("idle_timeout", 48'(busy8 || busy4), 48'd0);
   endtask

   task automatic decode(input int inst, output logic [23:0] l, output logic [23:0] r,
                         output bit found);
      logic [1:0] q[$];
      if (inst == 0) q = q8; else q = q4;
      found = 1'b0;
      l = '0; r = '0;
      for (int i = 1; i + 48 < q.size(); i++) begin
         if (!found && q[i-1][1] && !q[i][1]) begin
            found = 1'b1;
            for (int k = 1; k <= 24; k++) l = {l[22:0], q[i+k][0]};
            for (int k = 25; k <= 48; k++) r = {r[22:0], q[i+k][0]};
         end
      end
   endtask

   initial begin
      logic [23:0] dl, dr;
      bit found;
      int first8, second8, first4, second4, lat, cnt8, cnt4;

      vecs[0] = '{24'hA5F00F, 24'h3C0001, 24'hA5F00F, 24'h3C0001};
      vecs[1] = '{24'h800000, 24'h000001, 24'h800000, 24'h000001};
      vecs[2] = '{24'hFFFFFF, 24'h000000, 24'hFFFFFF, 24'h000000};
      vecs[3] = '{24'h123456, 24'hABCDEF, 24'h123456, 24'hABCDEF};

      rst_n = 1'b0; en = 1'b0; lft = '0; rght = '0;
      m_run = '{0, 0}; m_n = '{0, 0}; m_l = '{0, 0}; m_r = '{0, 0};
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (3) tick();

      // First-sample latency: 2*SCLK_DIV+1 clks counting the enabling clk
      lft = 24'h111111; rght = 24'h222222; en = 1'b1;
      lat = 0;
      while (!smpl8 && lat < 200) begin tick(); lat++; end
      chk("first_smpl_latency", 48'(lat), 48'(2 * 8 + 1));

      // Reset mid-slot 10 of the first frame on the div-8 instance
      en = 1'b0; wait_idle();
      en = 1'b1; tick();
      repeat (2 * 8 * 11 + 3) tick();
      rst_n = 1'b0; en = 1'b0; tick();
      chk("reset_outputs8", 48'(act_out(0)), 48'(5'b01000));
      chk("reset_outputs4", 48'(act_out(1)), 48'(5'b01000));
      rst_n = 1'b1;
      repeat (40) tick();
      chk("stay_idle", 48'({busy8, busy4}), 48'd0);

      // Table-driven decode of rising-edge bits after the ws fall
      foreach (vecs[v]) begin
         en = 1'b0; wait_idle();
         q8.delete(); q4.delete();
         lft = vecs[v].l; rght = vecs[v].r; en = 1'b1;
         first8 = -1; second8 = -1; first4 = -1; second4 = -1;
         repeat (96 * 8 * 2 + 100) begin
            tick();
            if (smpl8) begin if (first8 < 0) first8 = cyc; else if (second8 < 0) second8 = cyc; end
            if (smpl4) begin if (first4 < 0) first4 = cyc; else if (second4 < 0) second4 = cyc; end
         end
         chk($sformatf("frame_len8_v%0d", v), 48'(second8 - first8), 48'(96 * 8));
         chk($sformatf("frame_len4_v%0d", v), 48'(second4 - first4), 48'(96 * 4));
         decode(0, dl, dr, found);
         chk($sformatf("decode8_v%0d", v), {dl, dr}, found ? {vecs[v].exp_l, vecs[v].exp_r} : ~{vecs[v].exp_l, vecs[v].exp_r});
         decode(1, dl, dr, found);
         chk($sformatf("decode4_v%0d", v), {dl, dr}, found ? {vecs[v].exp_l, vecs[v].exp_r} : ~{vecs[v].exp_l, vecs[v].exp_r});
      end

      // en dropped during slot 30: frame completes, no new sample request
      en = 1'b0; wait_idle();
      en = 1'b1; tick();
      repeat (2 * 8 * 31 + 3) tick();
      en = 1'b0;
      cnt8 = 0; cnt4 = 0;
      repeat (96 * 8) begin
         tick();
         if (smpl8) cnt8++;
         if (smpl4) cnt4++;
      end
      chk("no_smpl_after_drop", 48'({cnt8[15:0], cnt4[15:0]}), 48'd0);
      chk("idle_after_drop", 48'({busy8, ws8, busy4, ws4}), 48'(4'b0101));

      // Randomized samples and enable toggling
      en = 1'b1;
      repeat (4000) begin
         tick();
         lft  = 24'($urandom);
         rght = 24'($urandom);
         if ($urandom_range(0, 299) == 0) en = ~en;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
